// File: rtl/timer_pkg.sv
// Shared types and constants for the cascaded timer digit counters.
//   mode_t       : operator mode select (HOLD/SET/UP/DOWN)
//   cnt_state_t  : counter state machine states
//   *_MODULO     : default ranges for seconds, minutes and hours stages
//   mode_target(): state reached for a given mode outside of expiry
package timer_pkg;

  localparam int unsigned SEC_MODULO = 60;
  localparam int unsigned MIN_MODULO = 60;
  localparam int unsigned HR_MODULO  = 24;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SET  = 2'b01,
    MODE_UP   = 2'b10,
    MODE_DOWN = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SET        = 3'd1,
    ST_COUNT_UP   = 3'd2,
    ST_COUNT_DOWN = 3'd3,
    ST_EXPIRED    = 3'd4
  } cnt_state_t;

  // Direct mode-to-state mapping used whenever expiry does not intervene.
  function automatic cnt_state_t mode_target(mode_t m);
    cnt_state_t s;
    unique case (m)
      MODE_HOLD: s = ST_IDLE;
      MODE_SET:  s = ST_SET;
      MODE_UP:   s = ST_COUNT_UP;
      MODE_DOWN: s = ST_COUNT_DOWN;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/cascade_mod_counter_rise_edge_detect.sv
// Rising-edge detector for a debounced level input.
// Ports:
//   clk_1Hz : clock
//   reset   : synchronous, active-high; clears the history flop
//   sig_in  : debounced level
//   edge_c  : combinational, high while sig_in is high and was low last cycle
module rise_edge_detect (
  input  logic clk_1Hz,
  input  logic reset,
  input  logic sig_in,
  output logic edge_c
);

  logic sig_q;
  logic sig_d;

  always_comb sig_d = sig_in;

  always_ff @(posedge clk_1Hz) begin
    if (reset) sig_q <= 1'b0;
    else       sig_q <= sig_d;
  end

  assign edge_c = sig_in & ~sig_q;

endmodule

// File: rtl/cascade_mod_counter.sv
// Modulo-N timer digit counter with hold, manual set, count-up and countdown
// modes. Stages cascade through wrap_out (into the next stage's tick_in) and
// others_zero (all other stages at zero).
// Ports:
//   clk_1Hz, reset       : clock, synchronous active-high reset
//   enable, tick_in      : count strobe qualifier and strobe
//   mode[1:0]            : 00 HOLD, 01 SET, 10 UP, 11 DOWN
//   others_zero          : all other cascaded stages are zero
//   inc, dec             : set buttons (level, edge detected here)
//   load, load_value     : synchronous preset (clamped to MODULO-1)
//   clear                : acknowledges expiry
//   count                : registered current value
//   wrap_out             : combinational carry/borrow to the next stage
//   zero                 : combinational count == 0
//   finish               : registered expiry flag
// Build option: FINISH_LATCH_EN holds finish high for the whole EXPIRED state;
// otherwise finish is a one-cycle pulse on entry to EXPIRED.
module cascade_mod_counter
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH  = 6,
  parameter int unsigned MODULO = 60
) (
  input  logic             clk_1Hz,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             tick_in,
  input  logic             others_zero,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             wrap_out,
  output logic             zero,
  output logic             finish
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);

  cnt_state_t       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             finish_q, finish_d;
  logic             inc_edge, dec_edge;
  logic             wrap_c;
  logic             cnt_zero, cnt_max, tick_ok;
  logic [WIDTH-1:0] load_clamped;
  mode_t            mode_sel;

  rise_edge_detect u_inc_edge (
    .clk_1Hz (clk_1Hz),
    .reset   (reset),
    .sig_in  (inc),
    .edge_c  (inc_edge)
  );

  rise_edge_detect u_dec_edge (
    .clk_1Hz (clk_1Hz),
    .reset   (reset),
    .sig_in  (dec),
    .edge_c  (dec_edge)
  );

  assign mode_sel     = mode_t'(mode);
  assign cnt_zero     = (count_q == '0);
  assign cnt_max      = (count_q == MAX_VAL);
  assign tick_ok      = enable & tick_in;
  assign load_clamped = (32'(load_value) >= MODULO) ? MAX_VAL : load_value;

  // State register
  always_ff @(posedge clk_1Hz) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      finish_q <= finish_d;
    end
  end

  // Next state, count action and carry/borrow
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    finish_d = 1'b0;
    wrap_c   = 1'b0;

    if (state_q == ST_EXPIRED) begin
      if (mode_sel != MODE_DOWN)  state_d = mode_target(mode_sel);
      else if (clear)             state_d = ST_IDLE;
    end else if (state_q == ST_COUNT_DOWN && cnt_zero && others_zero) begin
      state_d = ST_EXPIRED;
    end else begin
      state_d = mode_target(mode_sel);
    end

    case (state_q)
      ST_SET: begin
        // Simultaneous edges cancel; wrap_out never asserts while setting.
        if (inc_edge && !dec_edge)
          count_d = cnt_max ? '0 : count_q + WIDTH'(1);
        else if (dec_edge && !inc_edge)
          count_d = cnt_zero ? MAX_VAL : count_q - WIDTH'(1);
      end
      ST_COUNT_UP: begin
        if (tick_ok) begin
          if (cnt_max) begin
            count_d = '0;
            wrap_c  = 1'b1;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
      end
      ST_COUNT_DOWN: begin
        // All-zero is left alone: expiry handles it via the state change.
        if (tick_ok) begin
          if (!cnt_zero) begin
            count_d = count_q - WIDTH'(1);
          end else if (!others_zero) begin
            count_d = MAX_VAL;
            wrap_c  = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // Load overrides the state action, including its carry/borrow.
    if (load) begin
      count_d = load_clamped;
      wrap_c  = 1'b0;
    end

`ifdef FINISH_LATCH_EN
    finish_d = (state_d == ST_EXPIRED);
`else
    finish_d = (state_d == ST_EXPIRED) && (state_q != ST_EXPIRED);
`endif

    if (reset) wrap_c = 1'b0;
  end

  assign count    = count_q;
  assign finish   = finish_q;
  assign wrap_out = wrap_c;
  assign zero     = cnt_zero;

endmodule

// File: tb/tb_cascade_mod_counter.sv
// Scoreboard bench for cascade_mod_counter (WIDTH=7, MODULO=60).
// Expectations are queued while driving each cycle; combinational ones are
// checked before the clock edge, registered ones just after it.
module tb_cascade_mod_counter;
  import timer_pkg::*;

  localparam int unsigned WIDTH  = 7;
  localparam int unsigned MODULO = 60;
`ifdef FINISH_LATCH_EN
  localparam int LATCH = 1;
`else
  localparam int LATCH = 0;
`endif

  localparam int SEL_COUNT  = 0;
  localparam int SEL_FINISH = 1;
  localparam int SEL_STATE  = 2;
  localparam int SEL_WRAP   = 3;
  localparam int SEL_ZERO   = 4;

  typedef struct {
    string tag;
    int    sel;
    int    val;
  } exp_t;

  logic             clk_1Hz = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic             tick_in = 1'b0;
  logic             others_zero = 1'b1;
  logic             inc = 1'b0;
  logic             dec = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_value = '0;
  logic             clear = 1'b0;
  logic [WIDTH-1:0] count;
  logic             wrap_out;
  logic             zero;
  logic             finish;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t comb_q[$];
  exp_t reg_q[$];

  cascade_mod_counter #(.WIDTH(WIDTH), .MODULO(MODULO)) dut (
    .clk_1Hz     (clk_1Hz),
    .reset       (reset),
    .enable      (enable),
    .mode        (mode),
    .tick_in     (tick_in),
    .others_zero (others_zero),
    .inc         (inc),
    .dec         (dec),
    .load        (load),
    .load_value  (load_value),
    .clear       (clear),
    .count       (count),
    .wrap_out    (wrap_out),
    .zero        (zero),
    .finish      (finish)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sample(input int sel);
    case (sel)
      SEL_COUNT:  return int'(count);
      SEL_FINISH: return int'(finish);
      SEL_STATE:  return int'(dut.state_q);
      SEL_WRAP:   return int'(wrap_out);
      default:    return int'(zero);
    endcase
  endfunction

  function automatic exp_t mk(input string tag, input int sel, input int val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    return e;
  endfunction

  task automatic exp_comb(input string tag, input int sel, input int val);
    comb_q.push_back(mk(tag, sel, val));
  endtask

  task automatic exp_reg(input string tag, input int sel, input int val);
    reg_q.push_back(mk(tag, sel, val));
  endtask

  // One clock: settle, check pre-edge expectations, clock, check registered ones.
  task automatic step();
    exp_t e;
    #1;
    while (comb_q.size() > 0) begin
      e = comb_q.pop_front();
      check(e.tag, sample(e.sel), e.val);
    end
    @(posedge clk_1Hz);
    #1;
    while (reg_q.size() > 0) begin
      e = reg_q.pop_front();
      check(e.tag, sample(e.sel), e.val);
    end
  endtask

  int m;

  initial begin
    // Reset state
    reset = 1'b1;
    exp_reg("rst_count", SEL_COUNT, 0);
    exp_reg("rst_finish", SEL_FINISH, 0);
    exp_reg("rst_state", SEL_STATE, int'(ST_IDLE));
    step();
    reset = 1'b0;
    exp_comb("rst_zero", SEL_ZERO, 1);
    exp_comb("rst_wrap", SEL_WRAP, 0);
    step();

    // Count up through a full wrap
    mode = 2'b10; enable = 1'b1;
    step();
    tick_in = 1'b1;
    m = 0;
    for (int i = 0; i < 60; i++) begin
      exp_comb($sformatf("up_wrap%0d", i), SEL_WRAP, (m == 59) ? 1 : 0);
      m = (m + 1) % 60;
      exp_reg($sformatf("up_cnt%0d", i), SEL_COUNT, m);
      step();
    end
    tick_in = 1'b0;

    // Manual set
    mode = 2'b01;
    exp_reg("set_enter", SEL_STATE, int'(ST_SET));
    step();
    dec = 1'b1;
    exp_comb("set_dec_wrap", SEL_WRAP, 0);
    exp_reg("set_dec_0", SEL_COUNT, 59);
    step();
    dec = 1'b0;
    step();
    inc = 1'b1;
    exp_reg("set_inc_59", SEL_COUNT, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      exp_reg($sformatf("set_inc_hold%0d", i), SEL_COUNT, 0);
      step();
    end
    inc = 1'b0;
    step();
    inc = 1'b1; dec = 1'b1;
    exp_reg("set_both", SEL_COUNT, 0);
    step();
    inc = 1'b0; dec = 1'b0;
    step();

    // Load clamping and load priority over counting
    load = 1'b1; load_value = WIDTH'(75);
    exp_reg("load_clamp", SEL_COUNT, 59);
    step();
    load = 1'b0; mode = 2'b10;
    step();
    load = 1'b1; load_value = WIDTH'(10); tick_in = 1'b1;
    exp_comb("load_nowrap", SEL_WRAP, 0);
    exp_reg("load_over_tick", SEL_COUNT, 10);
    step();
    load = 1'b0; tick_in = 1'b0;

    // Countdown borrow and expiry
    mode = 2'b11; others_zero = 1'b0; load = 1'b1; load_value = '0;
    step();
    load = 1'b0; tick_in = 1'b1;
    exp_comb("dn_borrow", SEL_WRAP, 1);
    exp_reg("dn_borrow_cnt", SEL_COUNT, 59);
    step();
    tick_in = 1'b0; load = 1'b1; load_value = WIDTH'(1);
    step();
    load = 1'b0; others_zero = 1'b1; tick_in = 1'b1;
    exp_comb("dn_1_wrap", SEL_WRAP, 0);
    exp_reg("dn_to_0", SEL_COUNT, 0);
    exp_reg("dn_fin_early", SEL_FINISH, 0);
    step();
    tick_in = 1'b0;
    exp_comb("dn_zero", SEL_ZERO, 1);
    exp_reg("exp_finish", SEL_FINISH, 1);
    exp_reg("exp_state", SEL_STATE, int'(ST_EXPIRED));
    step();
    for (int i = 0; i < 2; i++) begin
      exp_reg($sformatf("exp_hold_fin%0d", i), SEL_FINISH, LATCH);
      exp_reg($sformatf("exp_hold_st%0d", i), SEL_STATE, int'(ST_EXPIRED));
      step();
    end
    clear = 1'b1;
    exp_reg("clr_state", SEL_STATE, int'(ST_IDLE));
    exp_reg("clr_finish", SEL_FINISH, 0);
    step();
    clear = 1'b0; mode = 2'b00;
    step();

    // Reset mid-countdown
    mode = 2'b11; load = 1'b1; load_value = WIDTH'(37);
    exp_reg("pre_rst_cnt", SEL_COUNT, 37);
    step();
    load = 1'b0; tick_in = 1'b1; reset = 1'b1;
    exp_reg("midrst_cnt", SEL_COUNT, 0);
    exp_reg("midrst_state", SEL_STATE, int'(ST_IDLE));
    exp_reg("midrst_finish", SEL_FINISH, 0);
    step();
    reset = 1'b0; tick_in = 1'b0;

    // Entering countdown already at zero, then reset during expiry
    exp_reg("z_enter_st", SEL_STATE, int'(ST_COUNT_DOWN));
    exp_reg("z_enter_fin", SEL_FINISH, 0);
    step();
    exp_reg("z_exp_fin", SEL_FINISH, 1);
    exp_reg("z_exp_st", SEL_STATE, int'(ST_EXPIRED));
    step();
    reset = 1'b1;
    exp_reg("exprst_fin", SEL_FINISH, 0);
    exp_reg("exprst_st", SEL_STATE, int'(ST_IDLE));
    step();
    reset = 1'b0; mode = 2'b00;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cascade_mod_counter.md
# cascade_mod_counter

- Parametrised modulo-N timer digit counter for the VGA clock/timer display, generalising the fixed 0–59 minutes counter.
- Supports hold, manual set (increment/decrement), stopwatch count-up and countdown modes through one state machine.
- Counts once per accepted `tick_in` on the 1 Hz domain.
- Provides carry/borrow and zero outputs, so seconds/minutes/hours stages cascade without external glue.
- Drives the display digit logic and the expiry flag.

## Interface
- `WIDTH`, 6, count register width; `2**WIDTH >= MODULO` required.
- `MODULO`, 60, count range 0..MODULO-1; `MODULO >= 2`.
- `clk_1Hz`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `enable`  in  1  gates `tick_in` counting in COUNT_UP/COUNT_DOWN; no effect on SET or load.
- `mode`  in  2  00 HOLD, 01 SET, 10 UP, 11 DOWN.
- `tick_in`  in  1  count strobe: 1 for the seconds stage, `wrap_out` of the lower stage otherwise.
- `others_zero`  in  1  all other cascaded stages are zero; tie to 1 for a single stage.
- `inc`, `dec`  in  1 each  set buttons; debounced level; rising edge detected internally.
- `load`  in  1  synchronous preset strobe.
- `load_value`  in  WIDTH  preset value.
- `clear`  in  1  acknowledges expiry.
- `count`  out  WIDTH  current value; registered.
- `wrap_out`  out  1  carry (UP) or borrow (DOWN) to the next stage; combinational.
- `zero`  out  1  `count == 0`; combinational.
- `finish`  out  1  countdown expired; registered.

## Operation
- States: IDLE, SET, COUNT_UP, COUNT_DOWN, EXPIRED. The current registered state selects the count action; state changes take effect next cycle.
- State transitions, from any state except EXPIRED:
  - HOLD goes to IDLE.
  - SET goes to SET.
  - UP goes to COUNT_UP.
  - DOWN goes to COUNT_DOWN.
- COUNT_DOWN goes to EXPIRED when `count==0 && others_zero`.
- EXPIRED stays while `mode==DOWN && !clear`. Otherwise it takes the `mode` target, but DOWN with `clear` goes to IDLE.
- Count-update priority: reset, then load, then state action.
- Load: accepted in any state. `count <= load_value`, clamped to MODULO-1 if `load_value >= MODULO`. The state action is suppressed that cycle.
- SET action:
  - inc edge: +1, wrapping MODULO-1 to 0.
  - dec edge: -1, wrapping 0 to MODULO-1.
  - inc and dec edges in the same cycle: no change.
  - `wrap_out` stays 0 in SET.
- COUNT_UP action, on `enable && tick_in`:
  - `count==MODULO-1`: count goes to 0 and `wrap_out=1`.
  - Otherwise: +1.
- COUNT_DOWN action, on `enable && tick_in`:
  - `count!=0`: -1.
  - `count==0 && !others_zero`: count goes to MODULO-1 and `wrap_out=1`.
  - `count==0 && others_zero`: no change; expiry takes over.
- IDLE, EXPIRED: count holds.
- Edge detection: `inc_q`/`dec_q` registers; edge = `in & ~q`. Reset clears them to 0.
- Arithmetic is done in WIDTH bits. Values at or above MODULO are unreachable except via load, which clamps.

## Timing
- Reset values: count 0, state IDLE, finish 0, edge registers 0. Hence `zero=1`, `wrap_out=0`.
- `count` updates 1 cycle after the `tick_in`/edge/load sample.
- `wrap_out` is high in the same cycle as the `tick_in` that wraps, so an upper stage updates on the same edge.
- `finish` rises 1 cycle after COUNT_DOWN sees all-zero, i.e. on entry to EXPIRED.
- Entering COUNT_DOWN with everything already zero expires on the following cycle.
- Reset mid-count or mid-expiry wins immediately at the next edge.
- A `mode` change mid-wrap: the action of the current state completes first.

## Configuration
- `FINISH_LATCH_EN` defined: `finish` is held high for the whole EXPIRED state and drops the cycle after leaving it (`clear`, mode change or reset).
- `FINISH_LATCH_EN` undefined: `finish` is a single-cycle pulse on entry to EXPIRED. The state still remains EXPIRED until exit.

## Structure
- Package `timer_pkg`:
  - `mode_t` enum (HOLD/SET/UP/DOWN).
  - `cnt_state_t` enum (the five states).
  - Default constants `SEC_MODULO=60`, `MIN_MODULO=60`, `HR_MODULO=24`.
- One sub-module, `rise_edge_detect`, instantiated twice (inc, dec).

## Test plan
- Reset, then UP with enable, 60 ticks from 0 → count 0..59,0; `wrap_out=1` only on the tick at 59.
- SET at count 0: dec edge → 59; inc edge → 0; simultaneous inc+dec → unchanged; `inc` held high 5 cycles → only +1.
- load 75 with MODULO 60 → count 59; load 10 while in COUNT_UP with `tick_in` → count 10 (tick ignored).
- DOWN with count 0, `others_zero=0`, tick → count 59 and `wrap_out=1`; then count 0 with `others_zero=1` → EXPIRED and `finish=1` one cycle later.
- EXPIRED with `FINISH_LATCH_EN`: `finish` stays 1 until `clear`, then goes to IDLE; without the macro: `finish` high exactly 1 cycle.
- Reset asserted at count 37 in COUNT_DOWN → next edge count 0, state IDLE, `finish` 0.
